// File: rtl/spi_reg_bank.sv
// ---------------------------------------------------------------------------
// spi_reg_bank
//   Write-only SPI mode-0 slave feeding five 8-bit control registers that
//   drive the PWM peripheral directly. The SPI pins are oversampled in the
//   clk domain: each pin is synchronised, and SCLK/nCS edges are detected
//   from the synchronised values. A frame is 16 bits, MSB first:
//   {rw(1 = write), addr[6:0], data[7:0]}.
//
//   Handshake: there is no valid/ready pair here. The external controller
//   paces the link itself, and wr_strobe is a one-clk pulse that goes high
//   in the cycle where the committed value first appears on the register
//   outputs.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   sclk, copi, ncs   SPI pins, asynchronous to clk
//   en_reg_out_7_0    reg 0x00   en_reg_out_15_8  reg 0x01
//   en_reg_pwm_7_0    reg 0x02   en_reg_pwm_15_8  reg 0x03
//   pwm_duty_cycle    reg 0x04
//   wr_strobe         one-clk pulse per committed write to a valid address
// ---------------------------------------------------------------------------
module spi_reg_bank #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
    logic                   sclk_prev, ncs_prev;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, ncs_fall, ncs_rise;

    logic [4:0]  bit_cnt;
    logic [15:0] shift_reg;
    logic        clr_frame, shift_en, do_write;

    // Synchronisers. COPI uses the same depth as SCLK so the synced data bit
    // is still the one the controller presented at the matching SCLK rise.
    // Idle values (sclk low, ncs high) are restored by reset so that no
    // spurious edge appears when reset is released with the bus idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            ncs_prev  <= ncs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign ncs_fall  = ~ncs_s & ncs_prev;
    assign ncs_rise  = ncs_s & ~ncs_prev;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A falling nCS seen while already in SHIFT (a glitch
    // shorter than the synchroniser depth) has no effect: no restart.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (ncs_fall) state_nxt = ST_SHIFT;
            ST_SHIFT:  if (ncs_rise) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output / control decode. An SCLK rise coinciding with the nCS rise is
    // not counted, so the commit sees the count from before that cycle.
    always_comb begin
        clr_frame = 1'b0;
        shift_en  = 1'b0;
        do_write  = 1'b0;
        case (state)
            ST_IDLE:   clr_frame = ncs_fall;
            ST_SHIFT:  shift_en  = sclk_rise & ~ncs_rise & (bit_cnt < 5'd16);
            ST_COMMIT: do_write  = (bit_cnt == 5'd16) & shift_reg[15] &
                                   (shift_reg[14:8] <= MAX_ADDR);
            default:   ;
        endcase
    end

    // Frame capture. The counter stops at 16, so bits beyond the 16th in a
    // long frame are dropped and the first 16 stay in the shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 5'd0;
            shift_reg <= 16'h0000;
        end else if (clr_frame) begin
            bit_cnt   <= 5'd0;
            shift_reg <= 16'h0000;
        end else if (shift_en) begin
            bit_cnt   <= bit_cnt + 5'd1;
            shift_reg <= {shift_reg[14:0], copi_s};
        end
    end

    // Register file and write strobe. Registers and strobe update on the
    // same edge, so wr_strobe marks the first cycle the new value is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
            wr_strobe       <= 1'b0;
        end else begin
            wr_strobe <= do_write;
            if (do_write) begin
                case (shift_reg[14:8])
                    7'h00:   en_reg_out_7_0  <= shift_reg[7:0];
                    7'h01:   en_reg_out_15_8 <= shift_reg[7:0];
                    7'h02:   en_reg_pwm_7_0  <= shift_reg[7:0];
                    7'h03:   en_reg_pwm_15_8 <= shift_reg[7:0];
                    7'h04:   pwm_duty_cycle  <= shift_reg[7:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_bank
//   Table of SPI frames with hand-computed register contents after each
//   frame, plus hand-written sequences for reset behaviour and a reset that
//   lands in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_spi_reg_bank;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 4;   // clk periods per SCLK phase (>= SYNC_STAGES+1)
    localparam int WINDOW      = 10;  // clk cycles observed after nCS rise
    localparam int COMMIT_IDX  = SYNC_STAGES + 1;

    logic       clk;
    logic       rst_n;
    logic       sclk, copi, ncs;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;

    int checks = 0;
    int errors = 0;

    spi_reg_bank #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(7'h04)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_strobe       (wr_strobe)
    );

    // ---- clock / reset ----------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- helpers ----------------------------------------------------------
    function automatic logic [39:0] regs_now();
        return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
                en_reg_pwm_15_8, pwm_duty_cycle};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Drive nbits of 'bits' MSB first. Pins change on negedge clk only.
    task automatic shift_bits(input logic [31:0] bits, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = bits[i];
            wait_clks(HALF);
            sclk = 1'b1;
            wait_clks(HALF);
            sclk = 1'b0;
        end
        wait_clks(HALF);
    endtask

    // Raise nCS and watch a bounded window. Index j counts the posedges after
    // the one that first captures the rising nCS (j = 0 is that edge).
    task automatic close_frame(input logic [39:0] regs_before,
                               output int strobe_idx, output int strobe_cnt,
                               output logic [39:0] regs_pre_commit);
        strobe_idx      = -1;
        strobe_cnt      = 0;
        regs_pre_commit = '0;
        ncs = 1'b1;
        for (int j = 0; j < WINDOW; j++) begin
            @(negedge clk);
            if (j == COMMIT_IDX - 1) regs_pre_commit = regs_now();
            if (wr_strobe) begin
                if (strobe_idx < 0) strobe_idx = j;
                strobe_cnt++;
            end
        end
        if (regs_before === 40'hx) strobe_cnt = -1;
    endtask

    task automatic run_frame(input string name, input logic [31:0] bits,
                             input int nbits, input logic [39:0] exp_before,
                             input logic [39:0] exp_after, input logic exp_wr);
        int          s_idx, s_cnt;
        logic [39:0] pre;
        ncs = 1'b0;
        wait_clks(HALF);
        shift_bits(bits, nbits);
        close_frame(exp_before, s_idx, s_cnt, pre);
        check({name, ".hold_before_commit"}, 64'(pre), 64'(exp_before));
        check({name, ".regs"}, 64'(regs_now()), 64'(exp_after));
        check({name, ".strobe_cnt"}, 64'(s_cnt), exp_wr ? 64'd1 : 64'd0);
        if (exp_wr)
            check({name, ".strobe_idx"}, 64'(s_idx), 64'(COMMIT_IDX));
    endtask

    // ---- vector table -----------------------------------------------------
    typedef struct {
        string       name;
        logic [31:0] bits;
        int          nbits;
        logic [39:0] exp_regs;  // {out_7_0, out_15_8, pwm_7_0, pwm_15_8, duty}
        logic        exp_wr;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [39:0] model;

        vecs[0]  = '{"wr_a0_55",    32'h8055,  16, 40'h55_00_00_00_00, 1'b1};
        vecs[1]  = '{"wr_a1_f0",    32'h81F0,  16, 40'h55_F0_00_00_00, 1'b1};
        vecs[2]  = '{"wr_a2_0f",    32'h820F,  16, 40'h55_F0_0F_00_00, 1'b1};
        vecs[3]  = '{"wr_a3_aa",    32'h83AA,  16, 40'h55_F0_0F_AA_00, 1'b1};
        vecs[4]  = '{"wr_a4_80",    32'h8480,  16, 40'h55_F0_0F_AA_80, 1'b1};
        vecs[5]  = '{"read_04ff",   32'h04FF,  16, 40'h55_F0_0F_AA_80, 1'b0};
        vecs[6]  = '{"badaddr_85",  32'h85FF,  16, 40'h55_F0_0F_AA_80, 1'b0};
        vecs[7]  = '{"badaddr_7f",  32'hFF12,  16, 40'h55_F0_0F_AA_80, 1'b0};
        vecs[8]  = '{"short_12b",   32'h0812,  12, 40'h55_F0_0F_AA_80, 1'b0};
        vecs[9]  = '{"long_20b",    32'h8433F, 20, 40'h55_F0_0F_AA_33, 1'b1};
        vecs[10] = '{"wr_a0_zero",  32'h8000,  16, 40'h00_F0_0F_AA_33, 1'b1};

        // ---- reset with random pin activity -------------------------------
        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sclk = 1'($urandom_range(0, 1));
            copi = 1'($urandom_range(0, 1));
            ncs  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("reset.regs", 64'(regs_now()), 64'd0);
        check("reset.strobe", 64'(wr_strobe), 64'd0);
        sclk = 1'b0;
        copi = 1'b0;
        ncs  = 1'b1;
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(6);
        check("post_reset.regs", 64'(regs_now()), 64'd0);
        check("post_reset.strobe", 64'(wr_strobe), 64'd0);

        // ---- table-driven frames -----------------------------------------
        model = 40'h0;
        for (int v = 0; v < 11; v++) begin
            run_frame(vecs[v].name, vecs[v].bits, vecs[v].nbits, model,
                      vecs[v].exp_regs, vecs[v].exp_wr);
            model = vecs[v].exp_regs;
            wait_clks(3);
        end

        // ---- reset in the middle of a frame ------------------------------
        ncs = 1'b0;
        wait_clks(HALF);
        shift_bits(32'h80, 8);           // first 8 bits of 0x80FF
        rst_n = 1'b0;
        #1;
        check("midreset.async_regs", 64'(regs_now()), 64'd0);
        ncs  = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(6);
        check("midreset.idle_regs", 64'(regs_now()), 64'd0);
        check("midreset.idle_strobe", 64'(wr_strobe), 64'd0);
        run_frame("after_midreset", 32'h8011, 16, 40'h0,
                  40'h11_00_00_00_00, 1'b1);

        // ---- registers hold indefinitely between writes ------------------
        wait_clks(40);
        check("hold.regs", 64'(regs_now()), 64'h11_00_00_00_00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
